// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the oversampling UART receiver.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam int         DATA_BITS   = 8;
    localparam logic       START_BIT   = 1'b0;
    localparam logic       STOP_BIT    = 1'b1;
    localparam logic [5:0] PRESCALE_8  = 6'd8;
    localparam logic [5:0] PRESCALE_16 = 6'd16;
    localparam logic [5:0] PRESCALE_32 = 6'd32;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Parallel-side and serial-side signals of the UART receiver.
interface uart_rx_if;
    logic       RX_IN;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [5:0] Prescale;
    logic [7:0] P_DATA;
    logic       Data_valid;
    logic       par_err;
    logic       stp_err;

    // master drives the line and frame format; slave is the receiver.
    modport master (
        output RX_IN, PAR_EN, PAR_TYP, Prescale,
        input  P_DATA, Data_valid, par_err, stp_err
    );

    modport slave (
        input  RX_IN, PAR_EN, PAR_TYP, Prescale,
        output P_DATA, Data_valid, par_err, stp_err
    );
endinterface

// File: rtl/uart_rx_sampler.sv
// 3-point majority voter around the middle of each bit period.
module uart_rx_sampler
    import uart_rx_pkg::*;
(
    input  logic       CLK,
    input  logic       rst,
    input  logic       rx_s,
    input  logic [5:0] edge_cnt,
    input  logic [5:0] Prescale,
    output logic       sampled_bit,
    output logic       sample_done
);

    logic [5:0] mid;
    logic       s_early;
    logic       s_mid;

    assign mid = Prescale >> 1;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (rst) begin
            s_early <= 1'b1;
            s_mid   <= 1'b1;
        end else begin
            if (edge_cnt == mid - 6'd1) s_early <= rx_s;
            if (edge_cnt == mid)        s_mid   <= rx_s;
        end
    end

    // The third sample is the live rx_s, so the vote resolves in the same cycle.
    assign sample_done = (edge_cnt == mid + 6'd1);
    assign sampled_bit = majority3(s_early, s_mid, rx_s);

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: synchronizer, frame FSM, counters, shift
// register, parity/stop checks and registered outputs.
module uart_rx
    import uart_rx_pkg::*;
(
    input  logic     CLK,
    input  logic     rst,
    uart_rx_if.slave bus
);

    logic [1:0]           sync_q;
    logic                 rx_s;
    state_t               state;
    state_t               state_next;
    logic [5:0]           edge_cnt;
    logic [5:0]           edge_cnt_next;
    logic [2:0]           bit_cnt;
    logic [5:0]           prescale_q;
    logic                 par_en_q;
    logic                 par_typ_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_bad;
    logic                 stp_bad;
    logic                 sampled_bit;
    logic                 sample_done;
    logic                 start_det;
    logic                 edge_last;
    logic                 bit_last;
    logic                 frame_end;
    logic                 frame_good;
    logic                 parity_exp;
    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;
    logic                 par_err_q;
    logic                 stp_err_q;

    // Synchronizer resets to the idle line level so reset never looks like a start bit.
    always_ff @(posedge CLK) begin
        if (rst) sync_q <= 2'b11;
        else     sync_q <= {sync_q[0], bus.RX_IN};
    end

    assign rx_s       = sync_q[1];
    assign start_det  = (state == IDLE) && (rx_s == START_BIT);
    assign edge_last  = (edge_cnt == prescale_q - 6'd1);
    assign bit_last   = (bit_cnt == 3'(DATA_BITS - 1));
    assign frame_end  = (state == STOP) && edge_last;
    assign frame_good = !par_bad && !stp_bad;
    assign parity_exp = par_typ_q ? ~^shift_q : ^shift_q;

    uart_rx_sampler u_sampler (
        .CLK         (CLK),
        .rst         (rst),
        .rx_s        (rx_s),
        .edge_cnt    (edge_cnt),
        .Prescale    (prescale_q),
        .sampled_bit (sampled_bit),
        .sample_done (sample_done)
    );

    always_ff @(posedge CLK) begin
        if (rst) begin
            state    <= IDLE;
            edge_cnt <= '0;
        end else begin
            state    <= state_next;
            edge_cnt <= edge_cnt_next;
        end
    end

    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_det) state_next = START;
            START: begin
                if (sample_done && sampled_bit != START_BIT) state_next = IDLE;
                else if (edge_last)                          state_next = DATA;
            end
            DATA:    if (edge_last && bit_last) state_next = par_en_q ? PARITY : STOP;
            PARITY:  if (edge_last) state_next = STOP;
            STOP:    if (edge_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase

        // The 6-bit counter wraps on its own, so an illegal prescale still ends each bit.
        edge_cnt_next = edge_last ? 6'd0 : edge_cnt + 6'd1;
        if (state_next == IDLE)  edge_cnt_next = 6'd0;
        else if (state == IDLE)  edge_cnt_next = 6'd1;
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            prescale_q <= PRESCALE_8;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            bit_cnt    <= '0;
            shift_q    <= '0;
            par_bad    <= 1'b0;
            stp_bad    <= 1'b0;
        end else begin
            if (start_det) begin
                prescale_q <= bus.Prescale;
                par_en_q   <= bus.PAR_EN;
                par_typ_q  <= bus.PAR_TYP;
                bit_cnt    <= '0;
                par_bad    <= 1'b0;
                stp_bad    <= 1'b0;
            end
            if (state == DATA && sample_done) shift_q <= {sampled_bit, shift_q[DATA_BITS-1:1]};
            if (state == DATA && edge_last)   bit_cnt <= bit_cnt + 3'd1;
            if (state == PARITY && sample_done) par_bad <= (sampled_bit != parity_exp);
            if (state == STOP && sample_done)   stp_bad <= (sampled_bit != STOP_BIT);
        end
    end

    // Outcome lands in the first IDLE cycle after STOP.
    always_ff @(posedge CLK) begin
        if (rst) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            par_err_q <= 1'b0;
            stp_err_q <= 1'b0;
        end else begin
            valid_q   <= frame_end && frame_good;
            par_err_q <= frame_end && par_bad;
            stp_err_q <= frame_end && stp_bad;
            if (frame_end && frame_good) data_q <= shift_q;
        end
    end

    assign bus.P_DATA     = data_q;
    assign bus.Data_valid = valid_q;
    assign bus.par_err    = par_err_q;
    assign bus.stp_err    = stp_err_q;

endmodule

// File: doc/uart_rx.md
# uart_rx

Oversampling UART receiver, the downstream partner of the UART transmit stage: it consumes the serial line that the transmitter drives. It recovers frames of 1 start bit, 8 data bits LSB first, an optional parity bit and 1 stop bit. Each bit is sampled by a 3-point majority vote. It presents the byte on a parallel bus with a one-cycle valid strobe, and flags parity and stop-bit errors. Frame format matches the transmitter: PAR_EN enables parity, PAR_TYP selects the sense, and the line idles high.

## Interface
- No parameters. Oversampling ratio is a run-time input.
- CLK  in  1  single clock (oversampling clock); all logic on rising edge
- rst  in  1  synchronous, active-high reset
- RX_IN  in  1  serial line, asynchronous to CLK, idles high
- PAR_EN  in  1  1 = frame carries a parity bit
- PAR_TYP  in  1  0 = even, 1 = odd
- Prescale  in  6  oversampling ratio; legal values 8, 16, 32
- P_DATA  out  8  received byte; holds until the next good frame; reset 0x00
- Data_valid  out  1  one-cycle pulse when P_DATA updates; reset 0
- par_err  out  1  one-cycle pulse, parity mismatch; reset 0
- stp_err  out  1  one-cycle pulse, stop bit sampled 0; reset 0

## Operation
- RX_IN passes a 2-flop synchronizer whose flops reset to 1. All behaviour is defined on the synchronized signal rx_s, which lags RX_IN by 2 cycles.
- Start detection (cycle T): the cycle in which the FSM is IDLE and rx_s == 0.
  - Prescale, PAR_EN and PAR_TYP are latched at T. Changes mid-frame are ignored.
- Counters:
  - edge_cnt runs 0..P-1 per bit; cycle T is edge 0 of the start bit.
  - bit_cnt counts data bits 0..7.
- Sampling:
  - rx_s is captured at edges P/2-1, P/2 and P/2+1.
  - The bit value is the majority of the 3 samples, resolved at edge P/2+1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE→START on start detect.
  - START: if the voted value is 1 (glitch), return to IDLE at edge P/2+2 with no output. Otherwise go to DATA at edge P-1.
  - DATA: shift the voted bit into the byte LSB first. After bit 7 ends, go to PARITY if PAR_EN, else STOP.
  - PARITY: compare the voted bit with the expected bit. Expected bit is ^byte for even, ~^byte for odd.
  - STOP: at edge P-1, go to IDLE.
- Frame outcome, registered and output in the first IDLE cycle after STOP:
  - No error: P_DATA <= byte; Data_valid = 1.
  - Parity mismatch: par_err = 1; P_DATA unchanged; no Data_valid.
  - Stop bit 0: stp_err = 1; P_DATA unchanged; no Data_valid.
  - Both errors may pulse in the same cycle.
- Back-to-back frames: the outcome cycle is itself IDLE, so a start detected in that cycle begins the next frame without loss.
- Reset mid-frame: the next cycle is IDLE, counters are 0, all outputs are at their reset values, and no strobe is produced for the partial frame.
- An illegal Prescale is outside the contract; it must not hang the FSM, which returns to IDLE within 12·64 cycles.

## Timing
- Frame length N·P cycles, where N = 10 without parity and 11 with parity.
- Data_valid / par_err / stp_err pulse at cycle T + N·P.
  - That is T+2+N·P relative to the RX_IN falling edge at the pin.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Outputs assert for exactly one cycle per frame.

## Structure
- Package uart_rx_pkg:
  - state enum (IDLE, START, DATA, PARITY, STOP)
  - constants DATA_BITS = 8, START_BIT = 1'b0, STOP_BIT = 1'b1, and the legal prescale values 8/16/32
- Sub-module uart_rx_sampler: the 3-point majority voter.
  - Inputs: rx_s, edge_cnt, Prescale.
  - Outputs: sampled_bit and a sample_done strobe.
- Top level holds the synchronizer, FSM, counters, shift register, parity/stop check and output registers.

## Test plan
- P=8, PAR_EN=0, send 0xA5 → Data_valid at T+80, P_DATA=0xA5, par_err=stp_err=0.
- P=16, PAR_EN=1, PAR_TYP=0, send 0x3C with parity bit 0 → Data_valid at T+176, P_DATA=0x3C; then resend with parity bit 1 → par_err pulse, P_DATA still 0x3C.
- P=32, PAR_EN=1, PAR_TYP=1, 0x00 with stop bit 0 → stp_err pulse at T+352, no Data_valid.
- P=8, start pulse low for only 2 cycles → FSM back in IDLE by T+6, no output pulses.
- P=8, frames 0x55 then 0xF0 with zero idle gap → two Data_valid pulses exactly 80 cycles apart, correct bytes.
- P=16, assert rst at data bit 4 → outputs 0 next cycle, no strobe; the following clean frame 0x81 is received correctly.
